booth_mul_ctrl: RTL

Sequencing controller for the radix-16 Booth multiplier datapath. It accepts a multiply request through a valid/ready handshake and drives the load strobes of the multiplicand and multiplier registers. It then steps the Booth digit index and accumulator enables for WIDTH/4 iterations, and holds a result-valid flag until the consumer accepts it. It sits between the requesting logic and the multiplicand register, multiplier shift register, digit recoder and accumulator.

---
 rtl/mul_pkg.sv | 11 +
 rtl/booth_digit_cnt.sv | 24 ++
 rtl/booth_mul_ctrl.sv | 96 +++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared state type and digit-count helper for the radix-16 Booth multiplier
package mul_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} mul_ctrl_state_t;

    // Each radix-16 Booth digit consumes four multiplier bits.
    function automatic int n_digits(int width);
        return width / 4;
    endfunction

endpackage

// File: rtl/booth_digit_cnt.sv
// rtl/booth_digit_cnt.sv - modulo-N Booth digit counter with clear, enable and last flag
module booth_digit_cnt #(
    parameter int N  = 2,
    parameter int CW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          last
);

    assign last = (count == CW'(N - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= last ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/booth_mul_ctrl.sv
// rtl/booth_mul_ctrl.sv - radix-16 Booth multiplier sequencer; MUL_CTRL_ABORT_EN adds the abort port
module booth_mul_ctrl
    import mul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       load_mcand,
    output logic                       load_mplier,
    output logic                       acc_clr,
    output logic                       acc_en,
    output logic                       shift_en,
    output logic [$clog2(WIDTH/4)-1:0] digit_idx,
    output logic                       busy,
    output logic                       out_valid,
`ifdef MUL_CTRL_ABORT_EN
    input  logic                       abort,
`endif
    input  logic                       out_ready
);

    localparam int N_DIG = n_digits(WIDTH);
    localparam int DW    = $clog2(N_DIG);

    if ((WIDTH % 4 != 0) || (WIDTH < 8)) begin : g_bad_width
        $error("booth_mul_ctrl: WIDTH must be a multiple of 4 and at least 8");
    end

    mul_ctrl_state_t state;
    mul_ctrl_state_t state_nxt;
    logic            abort_hit;
    logic            cnt_last;
    logic [DW-1:0]   cnt;

`ifdef MUL_CTRL_ABORT_EN
    assign abort_hit = abort && ((state == LOAD) || (state == ITER));
`else
    assign abort_hit = 1'b0;
`endif

    // The counter only moves in ITER and wraps on the last digit, so it reads 0 everywhere else.
    booth_digit_cnt #(
        .N  (N_DIG),
        .CW (DW)
    ) u_digit_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   ((state == LOAD) || abort_hit),
        .en    ((state == ITER) && !abort_hit),
        .count (cnt),
        .last  (cnt_last)
    );

    assign digit_idx = cnt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = LOAD;
            LOAD:                   state_nxt = ITER;
            ITER:    if (cnt_last)  state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
        if (abort_hit) state_nxt = IDLE;
    end

    // Strobes are registered from the next state so each one is a clean Moore output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            load_mcand  <= 1'b0;
            load_mplier <= 1'b0;
            acc_clr     <= 1'b0;
            acc_en      <= 1'b0;
            shift_en    <= 1'b0;
            busy        <= 1'b0;
            out_valid   <= 1'b0;
        end else begin
            state       <= state_nxt;
            in_ready    <= (state_nxt == IDLE);
            load_mcand  <= (state_nxt == LOAD);
            load_mplier <= (state_nxt == LOAD);
            acc_clr     <= (state_nxt == LOAD);
            acc_en      <= (state_nxt == ITER);
            shift_en    <= (state_nxt == ITER);
            busy        <= (state_nxt == LOAD) || (state_nxt == ITER);
            out_valid   <= (state_nxt == DONE);
        end
    end

endmodule
